// File: rtl/flags_ctx_stack_if.sv
// ---------------------------------------------------------------------------
// flags_ctx_stack_if
// ALU flag-restore interface between the flags context stack and the ALU.
//   flags_in      : live ALU flags {O,S,Z,C}           (ALU -> stack)
//   alu_bubble    : bubble of the stage feeding the ALU (ALU -> stack)
//   flags_restore : restore value {28'b0,O,S,Z,C}       (stack -> ALU)
//   flags_we      : restore request, held until commit  (stack -> ALU)
// master = flags context stack (producer), slave = ALU.
// ---------------------------------------------------------------------------
interface flags_ctx_stack_if;
    logic [3:0]  flags_in;
    logic        alu_bubble;
    logic [31:0] flags_restore;
    logic        flags_we;

    modport master (
        input  flags_in,
        input  alu_bubble,
        output flags_restore,
        output flags_we
    );

    modport slave (
        output flags_in,
        output alu_bubble,
        input  flags_restore,
        input  flags_we
    );
endinterface

// File: rtl/flags_ctx_stack.sv
// ---------------------------------------------------------------------------
// flags_ctx_stack
// Saves the ALU condition flags on trap entry into a small LIFO and drives
// them back into the ALU on return-from-exception, holding the restore
// request until the ALU commits it (clk_en high and no bubble).
//
// Ports:
//   clk, rst_n  : core clock, asynchronous active-low reset
//   clk_en      : global enable; no state changes when 0
//   alu_if      : ALU restore interface (flags_in, alu_bubble in;
//                 flags_restore, flags_we out)
//   trap_push   : save alu_if.flags_in
//   rfe_pop     : restore top entry
//   csr_wr      : software overwrite of the top entry (csr_wdata[3:0])
//   csr_rdata   : top entry zero-extended, 0 when empty
//   count       : number of valid entries
//   busy        : restore in progress
//   stack_ovf   : sticky, push while full
//   stack_unf   : sticky, pop while empty
//   parity_err  : sticky, parity mismatch on pop (FLAGS_CTX_PARITY_EN only)
//
// Build option: define FLAGS_CTX_PARITY_EN to store an even-parity bit per
// entry; a corrupted entry restores as 0 and sets parity_err.
// ---------------------------------------------------------------------------
module flags_ctx_stack #(
    parameter int DEPTH = 8,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    flags_ctx_stack_if.master    alu_if,
    input  logic                 trap_push,
    input  logic                 rfe_pop,
    input  logic                 csr_wr,
    input  logic [31:0]          csr_wdata,
    output logic [31:0]          csr_rdata,
    output logic [SPW-1:0]       count,
    output logic                 busy,
    output logic                 stack_ovf,
`ifdef FLAGS_CTX_PARITY_EN
    output logic                 stack_unf,
    output logic                 parity_err
`else
    output logic                 stack_unf
`endif
);

    localparam int AW = $clog2(DEPTH);
`ifdef FLAGS_CTX_PARITY_EN
    localparam int EW = 5;   // {parity, O,S,Z,C}
`else
    localparam int EW = 4;
`endif

    typedef enum logic {IDLE, RESTORE} state_e;

    state_e          state_q, state_d;
    logic [SPW-1:0]  count_q, count_d;
    logic [3:0]      restore_q, restore_d;
    logic            bypass_q, bypass_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
`ifdef FLAGS_CTX_PARITY_EN
    logic            perr_q, perr_d;
`endif

    logic [EW-1:0]   stack_q [DEPTH];
    logic            stk_we;
    logic [AW-1:0]   stk_idx;
    logic [EW-1:0]   stk_wdata;

    logic [SPW-1:0]  top_cnt;
    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   push_idx;
    logic [EW-1:0]   top_entry;
    logic            full;
    logic            csr_wdata_unused;

    assign csr_wdata_unused = ^csr_wdata[31:4];

    assign top_cnt   = count_q - SPW'(1);
    assign top_idx   = top_cnt[AW-1:0];
    assign push_idx  = count_q[AW-1:0];
    assign top_entry = stack_q[top_idx];
    assign full      = (count_q == SPW'(DEPTH));

    function automatic logic [EW-1:0] mk_entry(input logic [3:0] f);
`ifdef FLAGS_CTX_PARITY_EN
        return {^f, f};
`else
        return f;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        restore_d = restore_q;
        bypass_d  = bypass_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
`ifdef FLAGS_CTX_PARITY_EN
        perr_d    = perr_q;
`endif
        stk_we    = 1'b0;
        stk_idx   = push_idx;
        stk_wdata = mk_entry(alu_if.flags_in);

        if (clk_en) begin
            // A push (also the one that aborts a restore) behaves the same
            // from both states; the restore it aborts is simply discarded.
            if (trap_push && !(state_q == IDLE && rfe_pop)) begin
                if (!full) begin
                    stk_we  = 1'b1;
                    count_d = count_q + SPW'(1);
                end else begin
                    ovf_d   = 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (trap_push && rfe_pop) begin
                        // Bypass: the saved value never touches storage.
                        restore_d = alu_if.flags_in;
                        bypass_d  = 1'b1;
                        state_d   = RESTORE;
                    end else if (rfe_pop && !trap_push) begin
                        if (count_q != '0) begin
                            restore_d = top_entry[3:0];
`ifdef FLAGS_CTX_PARITY_EN
                            if (^top_entry) begin
                                restore_d = 4'b0;
                                perr_d    = 1'b1;
                            end
`endif
                            bypass_d  = 1'b0;
                            state_d   = RESTORE;
                        end else begin
                            unf_d     = 1'b1;
                        end
                    end else if (csr_wr && !trap_push && count_q != '0) begin
                        stk_we    = 1'b1;
                        stk_idx   = top_idx;
                        stk_wdata = mk_entry(csr_wdata[3:0]);
                    end
                end
                RESTORE: begin
                    if (trap_push) begin
                        state_d  = IDLE;
                        bypass_d = 1'b0;
                    end else if (!alu_if.alu_bubble) begin
                        // Entry is retired only once the ALU has taken it.
                        state_d  = IDLE;
                        bypass_d = 1'b0;
                        if (!bypass_q) count_d = count_q - SPW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            restore_q <= '0;
            bypass_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
`ifdef FLAGS_CTX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            restore_q <= restore_d;
            bypass_q  <= bypass_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
`ifdef FLAGS_CTX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    // Storage is not reset; contents are meaningless above count.
    always_ff @(posedge clk) begin
        if (stk_we) stack_q[stk_idx] <= stk_wdata;
    end

    assign alu_if.flags_we      = (state_q == RESTORE);
    assign alu_if.flags_restore = {28'b0, restore_q};
    assign busy                 = (state_q == RESTORE);
    assign count                = count_q;
    assign stack_ovf            = ovf_q;
    assign stack_unf            = unf_q;
    assign csr_rdata            = (count_q != '0) ? {28'b0, top_entry[3:0]} : 32'b0;
`ifdef FLAGS_CTX_PARITY_EN
    assign parity_err           = perr_q;
`endif

endmodule

// File: doc/flags_ctx_stack.md
Name: flags_ctx_stack

Overview:
- Saves and restores the ALU condition flags across traps and interrupts.
- On trap entry it pushes the live ALU flags {O,S,Z,C} onto a small LIFO.
- On return-from-exception it pops the saved flags and drives them back into the ALU through flags_restore/flags_we, holding the request until the ALU actually commits it.
- Sits beside the ALU in the execute stage and is the producer side of the ALU flag-restore interface.

Parameters:
- DEPTH, 8, number of saved flag contexts (power of two, min 2).
- SPW, $clog2(DEPTH+1), width of stack-pointer/count.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; no state changes when 0
- flags_in  in  4  live ALU flags {O,S,Z,C}
- alu_bubble  in  1  bubble of the stage feeding the ALU; restore commits only when 0
- trap_push  in  1  trap/interrupt entry: save flags_in
- rfe_pop  in  1  return-from-exception: restore top entry
- csr_wr  in  1  software write of top saved entry
- csr_wdata  in  32  write data; bits [3:0] used
- csr_rdata  out  32  top saved entry zero-extended; 0 when empty
- flags_restore  out  32  restore value, zero-extended {28'b0,O,S,Z,C}
- flags_we  out  1  restore request to ALU
- count  out  SPW  number of valid entries
- busy  out  1  1 while in RESTORE state
- stack_ovf  out  1  sticky: push attempted while full
- stack_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, rst_n=0):
  - count=0, state=IDLE, flags_we=0, flags_restore=0, stack_ovf=0, stack_unf=0.
  - Storage contents are don't-care.
- All sequential updates occur at posedge clk only when clk_en=1. With clk_en=0, all outputs hold.
- States:
  - IDLE: flags_we=0.
  - RESTORE: flags_we=1, flags_restore registered.
- IDLE transitions and actions:
  - push only, count<DEPTH: stack[count]<=flags_in; count+1.
  - push only, count==DEPTH: entry dropped; stack_ovf<=1; count unchanged.
  - pop only, count>0: flags_restore<={28'b0,stack[count-1]}; go RESTORE. count is NOT decremented yet.
  - pop only, count==0: stack_unf<=1; stay IDLE; no flags_we.
  - push and pop same cycle: bypass. flags_restore<={28'b0,flags_in}; go RESTORE with bypass flag set; count unchanged; no storage write.
- RESTORE:
  - flags_we and flags_restore are held stable until accept = clk_en & ~alu_bubble.
  - On accept: return to IDLE. count-1 unless bypass.
  - Latency: pop in cycle N gives flags_we high from N+1. The ALU flags take the restored value at the first accepting edge.
  - rfe_pop in RESTORE: ignored (no unf, no queue).
  - trap_push in RESTORE: restore aborted. flags_we drops next cycle, count is not decremented, and the push executes as in IDLE, full checks included. Abort takes priority over accept in the same cycle.
- csr_wr:
  - count>0 and not RESTORE: stack[count-1]<=csr_wdata[3:0].
  - Otherwise ignored.
  - Same-cycle csr_wr with push: push wins; csr_wr is dropped.
- csr_rdata is combinational from the top entry.
- Sticky flags clear only on reset.
- Reset mid-RESTORE: flags_we deasserts immediately (async) and the context is lost.

Optional Feature:
- Macro: FLAGS_CTX_PARITY_EN
- Defined:
  - Each entry stores an even-parity bit over its 4 flags.
  - On pop, a parity mismatch sets a sticky output parity_err (1 bit, reset 0) and drives flags_restore=0 instead of the stored value. The restore handshake is otherwise unchanged.
  - csr_wr recomputes parity.
- Undefined: no parity storage; parity_err port absent.

Test Plan:
- Reset, push flags_in=4'b1010, pop, alu_bubble=0 → flags_we=1 one cycle, flags_restore=32'h0000000A, count 1→0 after accept.
- Pop with alu_bubble=1 for 3 cycles then 0 → flags_we and flags_restore=0xA held all 4 cycles; count decrements only at the 4th edge.
- Push 8 entries (0..7), 9th push → count=8, stack_ovf=1. Then 8 pops → restore values 7,6,…,0 in order.
- Pop at count=0 → stack_unf=1, flags_we stays 0. Same-cycle push 4'b0110 + pop → flags_restore=0x6, count unchanged (0).
- Push 0x3, pop, trap_push(flags_in=0x5) during RESTORE → flags_we drops, count=2, top=0x5. Then csr_wr 0xF → csr_rdata=0xF; next pop restores 0xF.
- clk_en=0 while asserting push/pop → no state change. With FLAGS_CTX_PARITY_EN, force a stored bit flip → parity_err=1, restore=0.
